// File: rtl/vc_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : vc_rr_arbiter_pkg
// Desc    : shared defaults and FSM encodings for the VC read scheduler
// Rev     : 1.0  initial release
// ============================================================================
package vc_rr_arbiter_pkg;

    localparam int c_num_vc   = 4;
    localparam int c_bw       = 4;
    localparam int c_weight_w = 2;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_serve = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;

endpackage
`default_nettype wire

// File: rtl/vc_rr_arbiter_rr_next_sel.sv
`default_nettype none
// ============================================================================
// Module : rr_next_sel
// Desc   : rotating-priority encoder, first set req bit at or after base
// Rev    : 1.0  initial release
// ============================================================================
module rr_next_sel
    import vc_rr_arbiter_pkg::*;
#(
    parameter int NUM_VC = c_num_vc,
    parameter int IDX_W  = $clog2(NUM_VC)
) (
    input  logic [NUM_VC-1:0] req,
    input  logic [IDX_W-1:0]  base,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Scan farthest offset first so the nearest requester wins; NUM_VC is a
    // power of two, so the index sum wraps naturally.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (req[base + IDX_W'(k)]) begin
                idx   = base + IDX_W'(k);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : vc_rr_arbiter
// Desc   : weighted round-robin reader of per-VC FIFOs into one egress FIFO
// Rev    : 1.0  initial release
// ============================================================================
module vc_rr_arbiter
    import vc_rr_arbiter_pkg::*;
#(
    parameter int NUM_VC   = c_num_vc,
    parameter int BW       = c_bw,
    parameter int WEIGHT_W = c_weight_w
) (
    input  logic                         clk,
    input  logic                         reset_L,
    input  logic [NUM_VC-1:0]            vc_empty,
    input  logic [NUM_VC*BW-1:0]         vc_data_out,
    output logic [NUM_VC-1:0]            vc_rd,
    input  logic [NUM_VC*WEIGHT_W-1:0]   cfg_weight,
    input  logic                         down_almost_full,
    input  logic                         down_full,
    output logic                         down_wr,
    output logic [BW-1:0]                down_data_in,
    output logic [$clog2(NUM_VC)-1:0]    active_vc,
    output logic                         error_output
);

    localparam int IDX_W = $clog2(NUM_VC);

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_active_vc;
    logic [WEIGHT_W:0]   r_credit;
    logic [WEIGHT_W-1:0] r_weight;
    logic                r_down_wr;
    logic [IDX_W-1:0]    r_rd_vc;
    logic                r_error;

    logic                w_any_req;
    logic                w_rd_issue;
    logic                w_rotate;
    logic [IDX_W-1:0]    w_sel_base;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_sel_valid;
    logic [WEIGHT_W-1:0] w_sel_weight;
    logic [WEIGHT_W:0]   w_credit_inc;

    assign w_any_req    = ~&vc_empty;
    assign w_rd_issue   = (r_state == c_st_serve) && !vc_empty[r_active_vc] && !down_almost_full;
    assign w_credit_inc = (&r_credit) ? r_credit : r_credit + (WEIGHT_W+1)'(1);
    // A turn ends after weight+1 reads, or immediately if the holder ran dry.
    assign w_rotate     = w_rd_issue ? (r_credit == {1'b0, r_weight}) : vc_empty[r_active_vc];
    assign w_sel_base   = (r_state == c_st_serve) ? r_active_vc + IDX_W'(1) : r_active_vc;
    assign w_sel_weight = cfg_weight[int'(w_sel_idx)*WEIGHT_W +: WEIGHT_W];

    rr_next_sel #(
        .NUM_VC (NUM_VC),
        .IDX_W  (IDX_W)
    ) u_next_sel (
        .req   (~vc_empty),
        .base  (w_sel_base),
        .idx   (w_sel_idx),
        .valid (w_sel_valid)
    );

    always_comb begin
        vc_rd = '0;
        if (w_rd_issue) vc_rd[r_active_vc] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= c_st_idle;
            r_active_vc <= '0;
            r_credit    <= '0;
            r_weight    <= '0;
            r_down_wr   <= 1'b0;
            r_rd_vc     <= '0;
            r_error     <= 1'b0;
        end else begin
            r_down_wr <= w_rd_issue;
            if (w_rd_issue) r_rd_vc <= r_active_vc;
            if (r_down_wr && down_full) r_error <= 1'b1;

            case (r_state)
                c_st_idle: begin
                    if (w_sel_valid) begin
                        r_state     <= c_st_serve;
                        r_active_vc <= w_sel_idx;
                        r_credit    <= '0;
                        r_weight    <= w_sel_weight;
                    end
                end
                c_st_serve: begin
                    if (down_almost_full) begin
                        r_state <= c_st_pause;
                    end else if (!w_any_req) begin
                        r_state <= c_st_idle;
                    end else if (w_rotate) begin
                        r_active_vc <= w_sel_idx;
                        r_credit    <= '0;
                        r_weight    <= w_sel_weight;
                    end else if (w_rd_issue) begin
                        r_credit <= w_credit_inc;
                    end
                end
                c_st_pause: begin
                    if (!down_almost_full) r_state <= w_any_req ? c_st_serve : c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // The VC FIFO presents the popped word one cycle after its read strobe.
    assign down_wr      = r_down_wr;
    assign down_data_in = r_down_wr ? vc_data_out[int'(r_rd_vc)*BW +: BW] : '0;
    assign active_vc    = r_active_vc;
    assign error_output = r_error;

endmodule
`default_nettype wire

// File: tb/tb_vc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_vc_rr_arbiter
// Desc   : self-checking bench, directed vector tables plus random traffic
// Rev    : 1.0  initial release
// ============================================================================
module tb_vc_rr_arbiter;

    localparam int NUM_VC   = 4;
    localparam int BW       = 4;
    localparam int WEIGHT_W = 2;
    localparam int IDX_W    = 2;

    logic                       clk = 1'b0;
    logic                       reset_L;
    logic [NUM_VC-1:0]          vc_empty;
    logic [NUM_VC*BW-1:0]       vc_data_out;
    logic [NUM_VC-1:0]          vc_rd;
    logic [NUM_VC*WEIGHT_W-1:0] cfg_weight;
    logic                       down_almost_full;
    logic                       down_full;
    logic                       down_wr;
    logic [BW-1:0]              down_data_in;
    logic [IDX_W-1:0]           active_vc;
    logic                       error_output;

    always #5 clk = ~clk;

    vc_rr_arbiter #(
        .NUM_VC   (NUM_VC),
        .BW       (BW),
        .WEIGHT_W (WEIGHT_W)
    ) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .vc_empty         (vc_empty),
        .vc_data_out      (vc_data_out),
        .vc_rd            (vc_rd),
        .cfg_weight       (cfg_weight),
        .down_almost_full (down_almost_full),
        .down_full        (down_full),
        .down_wr          (down_wr),
        .down_data_in     (down_data_in),
        .active_vc        (active_vc),
        .error_output     (error_output)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] q[NUM_VC][$];

    logic [NUM_VC-1:0] s_rd;
    logic              s_wr;
    logic [BW-1:0]     s_data;
    logic              s_err;
    logic [IDX_W-1:0]  s_act;

    // Reference model: mode 0 idle, 1 serving, 2 paused; a turn allows quota reads.
    logic          use_model = 1'b0;
    int            m_mode, m_vc, m_cnt, m_quota;
    logic          m_wr_pend, m_err;
    logic [BW-1:0] m_word;

    typedef struct {
        logic          af;
        logic          full;
        logic [3:0]    rd;
        logic          wr;
        logic [BW-1:0] data;
        logic          err;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic af, input logic full, input logic [3:0] rd,
                                input logic wr, input logic [BW-1:0] data, input logic err);
        vec_t v;
        v.af = af; v.full = full; v.rd = rd; v.wr = wr; v.data = data; v.err = err;
        vecs.push_back(v);
    endfunction

    function automatic int first_ne(input int start);
        for (int k = 0; k < NUM_VC; k++) begin
            if (q[(start + k) % NUM_VC].size() > 0) return (start + k) % NUM_VC;
        end
        return -1;
    endfunction

    function automatic int quota_of(input int v);
        logic [WEIGHT_W-1:0] w;
        w = cfg_weight[v*WEIGHT_W +: WEIGHT_W];
        return int'(w) + 1;
    endfunction

    function automatic void refresh_empty();
        for (int v = 0; v < NUM_VC; v++) vc_empty[v] = (q[v].size() == 0);
    endfunction

    function automatic void clear_q();
        for (int v = 0; v < NUM_VC; v++) q[v].delete();
    endfunction

    function automatic void load(input int v, input int n);
        for (int k = 0; k < n; k++) q[v].push_back(BW'(v*4 + k));
    endfunction

    task automatic model_step(input logic af, input logic full);
        int  exp_v;
        logic [3:0] exp_rd;
        bit  any;
        exp_v  = (m_mode == 1 && q[m_vc].size() > 0 && !af) ? m_vc : -1;
        exp_rd = (exp_v >= 0) ? 4'(1 << exp_v) : 4'b0000;
        chk("rand.vc_rd", s_rd, exp_rd);
        chk("rand.active_vc", s_act, m_vc);
        chk("rand.down_wr", s_wr, m_wr_pend);
        if (m_wr_pend) chk("rand.down_data_in", s_data, m_word);
        chk("rand.error_output", s_err, m_err);

        m_err     = m_err | (m_wr_pend & full);
        m_wr_pend = (exp_v >= 0);
        if (exp_v >= 0) m_word = q[exp_v][0];
        any = (first_ne(0) >= 0);
        case (m_mode)
            0: if (any) begin
                m_vc = first_ne(m_vc); m_mode = 1; m_cnt = 0; m_quota = quota_of(m_vc);
            end
            1: begin
                if (af) m_mode = 2;
                else if (!any) m_mode = 0;
                else if (exp_v < 0 || m_cnt + 1 == m_quota) begin
                    m_vc = first_ne((m_vc + 1) % NUM_VC); m_cnt = 0; m_quota = quota_of(m_vc);
                end else m_cnt++;
            end
            default: if (!af) m_mode = any ? 1 : 0;
        endcase
    endtask

    // One clock: apply inputs, sample at negedge, then model the FIFO pops.
    task automatic tick(input logic af, input logic full);
        down_almost_full = af;
        down_full        = full;
        refresh_empty();
        @(negedge clk);
        s_rd = vc_rd; s_wr = down_wr; s_data = down_data_in; s_err = error_output; s_act = active_vc;
        if (use_model) model_step(af, full);
        @(posedge clk);
        #1;
        for (int v = 0; v < NUM_VC; v++) begin
            if (s_rd[v]) begin
                chk("rd_nonempty", 32'(q[v].size() > 0), 1);
                if (q[v].size() > 0) vc_data_out[v*BW +: BW] = q[v].pop_front();
            end
        end
    endtask

    task automatic do_reset();
        reset_L          = 1'b0;
        vc_data_out      = '0;
        down_almost_full = 1'b0;
        down_full        = 1'b0;
        refresh_empty();
        repeat (2) begin
            @(negedge clk);
            chk("rst.vc_rd", vc_rd, 0);
            chk("rst.down_wr", down_wr, 0);
            chk("rst.down_data_in", down_data_in, 0);
            chk("rst.error_output", error_output, 0);
            chk("rst.active_vc", active_vc, 0);
        end
        @(posedge clk);
        #1;
        reset_L   = 1'b1;
        m_mode    = 0; m_vc = 0; m_cnt = 0; m_quota = 1;
        m_wr_pend = 1'b0; m_err = 1'b0; m_word = '0;
    endtask

    task automatic run_vecs(input string name);
        foreach (vecs[i]) begin
            tick(vecs[i].af, vecs[i].full);
            chk($sformatf("%s[%0d].vc_rd", name, i), s_rd, vecs[i].rd);
            chk($sformatf("%s[%0d].down_wr", name, i), s_wr, vecs[i].wr);
            if (vecs[i].wr) chk($sformatf("%s[%0d].down_data_in", name, i), s_data, vecs[i].data);
            chk($sformatf("%s[%0d].error_output", name, i), s_err, vecs[i].err);
        end
        vecs.delete();
    endtask

    initial begin
        reset_L = 1'b0; vc_empty = '1; vc_data_out = '0; cfg_weight = '0;
        down_almost_full = 1'b0; down_full = 1'b0;

        // Equal weights: one read per VC per turn, strict rotation.
        clear_q(); for (int v = 0; v < NUM_VC; v++) load(v, 3);
        cfg_weight = 8'h00;
        do_reset();
        add(0,0,4'b0000,0,4'h0,0); add(0,0,4'b0001,0,4'h0,0); add(0,0,4'b0010,1,4'h0,0);
        add(0,0,4'b0100,1,4'h4,0); add(0,0,4'b1000,1,4'h8,0); add(0,0,4'b0001,1,4'hC,0);
        add(0,0,4'b0010,1,4'h1,0);
        run_vecs("rr_equal");

        // VC0 weight 2: three back-to-back reads, then one each for the rest.
        clear_q(); for (int v = 0; v < NUM_VC; v++) load(v, 3);
        cfg_weight = 8'b0000_0010;
        do_reset();
        add(0,0,4'b0000,0,4'h0,0); add(0,0,4'b0001,0,4'h0,0); add(0,0,4'b0001,1,4'h0,0);
        add(0,0,4'b0001,1,4'h1,0); add(0,0,4'b0010,1,4'h2,0); add(0,0,4'b0100,1,4'h4,0);
        add(0,0,4'b1000,1,4'h8,0); add(0,0,4'b0010,1,4'hC,0);
        run_vecs("weighted");

        // Sole non-empty VC re-grants itself, then the arbiter idles.
        clear_q(); q[2].push_back(4'hA); q[2].push_back(4'hB);
        cfg_weight = 8'h00;
        do_reset();
        add(0,0,4'b0000,0,4'h0,0); add(0,0,4'b0100,0,4'h0,0); add(0,0,4'b0100,1,4'hA,0);
        add(0,0,4'b0000,1,4'hB,0); add(0,0,4'b0000,0,4'h0,0);
        run_vecs("single_vc");
        chk("single_vc.active_vc", s_act, 2);

        // Backpressure mid-burst on VC1 (weight 2); credit survives the pause.
        clear_q(); load(1, 4); load(2, 1);
        cfg_weight = 8'b0000_1000;
        do_reset();
        add(0,0,4'b0000,0,4'h0,0); add(0,0,4'b0010,0,4'h0,0); add(1,0,4'b0000,1,4'h4,0);
        add(1,0,4'b0000,0,4'h0,0); add(0,0,4'b0000,0,4'h0,0); add(0,0,4'b0010,0,4'h0,0);
        add(0,0,4'b0010,1,4'h5,0); add(0,0,4'b0100,1,4'h6,0); add(0,0,4'b0010,1,4'h8,0);
        run_vecs("pause");

        // Write into a full egress FIFO sets the sticky error until reset.
        clear_q(); load(0, 1);
        cfg_weight = 8'h00;
        do_reset();
        add(0,0,4'b0000,0,4'h0,0); add(0,0,4'b0001,0,4'h0,0); add(0,1,4'b0000,1,4'h0,0);
        add(0,0,4'b0000,0,4'h0,1); add(0,0,4'b0000,0,4'h0,1);
        run_vecs("overflow");
        clear_q();
        do_reset();

        // Random traffic, weights and backpressure against the reference model.
        clear_q();
        cfg_weight = NUM_VC*WEIGHT_W'($urandom);
        do_reset();
        use_model = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 63) cfg_weight = NUM_VC*WEIGHT_W'($urandom);
            for (int v = 0; v < NUM_VC; v++) begin
                if ($urandom_range(0, 3) == 0 && q[v].size() < 8) q[v].push_back(BW'($urandom));
            end
            tick($urandom_range(0, 4) == 0, $urandom_range(0, 199) == 0);
        end
        use_model = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
